window_integral: RTL and testbench

WINDOW_INTEGRAL -- requirements
Module: window_integral

---
 rtl/window_integral_if.sv | 36 +++
 rtl/window_integral.sv | 148 ++++++++++++++
 tb/tb_window_integral.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/window_integral_if.sv
// Handshake bundle for window_integral: pixel stream in, integral reads out,
// plus window ownership and the sticky eot error flag.
interface window_integral_if #(
    parameter int W_DATA = 8,
    parameter int W_RA   = 10,
    parameter int W_II   = 18
);
    logic              din_valid;
    logic              din_ready;
    logic [W_DATA-1:0] din_data;
    logic [1:0]        din_eot;

    logic              rd_valid;
    logic              rd_ready;
    logic [W_RA-1:0]   rd_addr;
    logic              rd_data_valid;
    logic [W_II-1:0]   rd_data;

    logic              win_valid;
    logic              win_release;
    logic              eot_err;

    modport master (
        output din_valid, din_data, din_eot,
        output rd_valid, rd_addr, win_release,
        input  din_ready, rd_ready, rd_data_valid, rd_data,
        input  win_valid, eot_err
    );

    modport slave (
        input  din_valid, din_data, din_eot,
        input  rd_valid, rd_addr, win_release,
        output din_ready, rd_ready, rd_data_valid, rd_data,
        output win_valid, eot_err
    );
endinterface

// File: rtl/window_integral.sv
// Integral image of one raster window: fills in FILL, serves random reads
// in READY until the consumer releases the window.
module window_integral #(
    parameter int W_DATA         = 8,
    parameter int FEATURE_WIDTH  = 24,
    parameter int FEATURE_HEIGHT = 24
) (
    input  logic              clk,
    input  logic              rst,
    window_integral_if.slave  bus
);
    localparam int DEPTH = FEATURE_WIDTH * FEATURE_HEIGHT;
    localparam int W_RA  = $clog2(DEPTH);
    localparam int W_II  = W_DATA + $clog2(DEPTH);
    localparam int W_X   = (FEATURE_WIDTH > 1) ? $clog2(FEATURE_WIDTH) : 1;
    localparam int W_Y   = (FEATURE_HEIGHT > 1) ? $clog2(FEATURE_HEIGHT) : 1;

    localparam logic [W_X-1:0] X_LAST  = W_X'(FEATURE_WIDTH - 1);
    localparam logic [W_Y-1:0] Y_LAST  = W_Y'(FEATURE_HEIGHT - 1);
    localparam logic [W_RA:0]  DEPTH_C = (W_RA + 1)'(DEPTH);

    typedef enum logic {
        FILL  = 1'b0,
        READY = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [W_X-1:0]    x_q, x_d;
    logic [W_Y-1:0]    y_q, y_d;
    logic [W_RA-1:0]   addr_q, addr_d;
    logic [W_II-1:0]   row_sum_q, row_sum_d;
    logic              eot_err_q, eot_err_d;
    logic              rd_data_valid_q, rd_data_valid_d;
    logic [W_II-1:0]   rd_data_q, rd_data_d;

    logic [W_II-1:0]   line_q [FEATURE_WIDTH];
    logic [W_II-1:0]   mem_q  [DEPTH];

    logic              din_fire;
    logic              rd_fire;
    logic              x_last;
    logic              px_last;
    logic              rd_in_range;
    logic [1:0]        eot_exp;
    logic [W_II-1:0]   pix;
    logic [W_II-1:0]   row_acc;
    logic [W_II-1:0]   line_rd;
    logic [W_II-1:0]   mem_rd;
    logic [W_II-1:0]   ii;

    assign din_fire    = bus.din_valid && (state_q == FILL);
    assign rd_fire     = bus.rd_valid && (state_q == READY);
    assign x_last      = (x_q == X_LAST);
    assign px_last     = x_last && (y_q == Y_LAST);
    assign eot_exp     = {px_last, x_last};
    assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_C);

    assign pix     = W_II'(bus.din_data);
    assign line_rd = line_q[x_q];
    assign mem_rd  = mem_q[bus.rd_addr];

    // Zero row sum at x==0 and masked line at y==0 start each window cleanly.
    assign row_acc = ((x_q == '0) ? '0 : row_sum_q) + pix;
    assign ii      = row_acc + ((y_q == '0) ? '0 : line_rd);

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        addr_d    = addr_q;
        row_sum_d = row_sum_q;
        eot_err_d = eot_err_q;
        unique case (state_q)
            FILL: begin
                if (din_fire) begin
                    row_sum_d = row_acc;
                    if (bus.din_eot != eot_exp) begin
                        eot_err_d = 1'b1;
                    end
                    if (px_last) begin
                        state_d = READY;
                        x_d     = '0;
                        y_d     = '0;
                        addr_d  = '0;
                    end else if (x_last) begin
                        x_d    = '0;
                        y_d    = y_q + 1'b1;
                        addr_d = addr_q + 1'b1;
                    end else begin
                        x_d    = x_q + 1'b1;
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            READY: begin
                if (bus.win_release) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        rd_data_valid_d = rd_fire;
        rd_data_d       = rd_data_q;
        if (rd_fire) begin
            rd_data_d = rd_in_range ? mem_rd : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= FILL;
            x_q             <= '0;
            y_q             <= '0;
            addr_q          <= '0;
            row_sum_q       <= '0;
            eot_err_q       <= 1'b0;
            rd_data_valid_q <= 1'b0;
            rd_data_q       <= '0;
        end else begin
            state_q         <= state_d;
            x_q             <= x_d;
            y_q             <= y_d;
            addr_q          <= addr_d;
            row_sum_q       <= row_sum_d;
            eot_err_q       <= eot_err_d;
            rd_data_valid_q <= rd_data_valid_d;
            rd_data_q       <= rd_data_d;
        end
    end

    // Storage arrays carry no reset; every window rewrites all entries.
    always_ff @(posedge clk) begin
        if (din_fire) begin
            line_q[x_q]  <= ii;
            mem_q[addr_q] <= ii;
        end
    end

    assign bus.din_ready     = (state_q == FILL);
    assign bus.rd_ready      = (state_q == READY);
    assign bus.win_valid     = (state_q == READY);
    assign bus.rd_data_valid = rd_data_valid_q;
    assign bus.rd_data       = rd_data_q;
    assign bus.eot_err       = eot_err_q;
endmodule

// File: tb/tb_window_integral.sv
// Randomised bench for window_integral (4x4, 8-bit) against a direct
// double-sum integral model.
module tb_window_integral;
    localparam int FW = 4;
    localparam int FH = 4;
    localparam int N  = FW * FH;

    logic clk = 1'b0;
    logic rst = 1'b1;

    window_integral_if #(.W_DATA(8), .W_RA(4), .W_II(12)) bus ();

    window_integral #(
        .W_DATA(8),
        .FEATURE_WIDTH(FW),
        .FEATURE_HEIGHT(FH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int px [N];
    int ii_win [N];
    logic exp_err = 1'b0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int ii_ref(input int a);
        int x = a % FW;
        int y = a / FW;
        int s = 0;
        for (int j = 0; j <= y; j++)
            for (int i = 0; i <= x; i++)
                s += px[j * FW + i];
        return s;
    endfunction

    task automatic snap_window();
        for (int a = 0; a < N; a++) ii_win[a] = ii_ref(a);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic send_pixels(input int n, input int gap_pct,
                               input int bad_k, input logic [1:0] bad_xor,
                               input int rel_k);
        logic [1:0] eot;
        for (int k = 0; k < n; k++) begin
            while ($urandom_range(99) < gap_pct) begin
                bus.din_valid = 1'b0;
                idle(1);
            end
            eot = {k == N - 1, (k % FW) == FW - 1};
            if (k == bad_k) eot = eot ^ bad_xor;
            if (eot != {k == N - 1, (k % FW) == FW - 1}) exp_err = 1'b1;
            bus.din_valid   = 1'b1;
            bus.din_data    = 8'(px[k]);
            bus.din_eot     = eot;
            bus.win_release = (k == rel_k);
            if (k == N - 1) check("win_pre", bus.win_valid, 0);
            if (k == rel_k) check("rel_fill_rdy", bus.din_ready, 1);
            @(posedge clk);
            #1;
            bus.din_valid   = 1'b0;
            bus.win_release = 1'b0;
        end
        if (n == N) begin
            snap_window();
            check("win_post", bus.win_valid, 1);
            check("din_rdy_ready", bus.din_ready, 0);
            check("eot_err", bus.eot_err, exp_err);
        end
    endtask

    task automatic rd(input int addr);
        bus.rd_valid = 1'b1;
        bus.rd_addr  = 4'(addr);
        @(posedge clk);
        #1;
        bus.rd_valid = 1'b0;
        check($sformatf("rdv[%0d]", addr), bus.rd_data_valid, 1);
        check($sformatf("rd[%0d]", addr), bus.rd_data, ii_win[addr]);
    endtask

    task automatic release_win();
        bus.win_release = 1'b1;
        @(posedge clk);
        #1;
        bus.win_release = 1'b0;
        check("rel_win", bus.win_valid, 0);
        check("rel_rdy", bus.din_ready, 1);
    endtask

    task automatic fill_const(input int v);
        for (int k = 0; k < N; k++) px[k] = v;
    endtask

    initial begin
        bus.din_valid   = 1'b0;
        bus.din_data    = '0;
        bus.din_eot     = '0;
        bus.rd_valid    = 1'b0;
        bus.rd_addr     = '0;
        bus.win_release = 1'b0;
        do_reset();

        check("rst_din_rdy", bus.din_ready, 1);
        check("rst_rd_rdy", bus.rd_ready, 0);
        check("rst_win", bus.win_valid, 0);
        check("rst_rdv", bus.rd_data_valid, 0);
        check("rst_rd", bus.rd_data, 0);
        check("rst_err", bus.eot_err, 0);

        // reads in FILL are not accepted
        bus.rd_valid = 1'b1;
        bus.rd_addr  = 4'd3;
        idle(1);
        bus.rd_valid = 1'b0;
        check("fill_rdv", bus.rd_data_valid, 0);

        fill_const(1);
        send_pixels(N, 0, -1, 2'b00, -1);
        check("ones_15", ii_win[15], 16);
        check("ones_5", ii_win[5], 4);
        for (int a = 0; a < N; a++) rd(a);
        idle(1);
        check("rdv_drop", bus.rd_data_valid, 0);
        release_win();

        fill_const(255);
        send_pixels(N, 0, -1, 2'b00, -1);
        rd(15);
        rd(0);
        check("sat_15", ii_win[15], 4080);
        release_win();

        for (int k = 0; k < N; k++) px[k] = k;
        send_pixels(N, 40, -1, 2'b00, 6);
        bus.din_valid = 1'b1;
        bus.din_data  = 8'd99;
        for (int i = 0; i < 3; i++) begin
            check("ready_hold_rdy", bus.din_ready, 0);
            idle(1);
        end
        bus.din_valid = 1'b0;
        rd(3);
        rd(15);
        check("ramp_3", ii_win[3], 6);
        check("ramp_15", ii_win[15], 120);
        release_win();

        for (int k = 0; k < N; k++) px[k] = $urandom_range(255);
        send_pixels(N, 20, 2, 2'b01, -1);
        check("err_set", bus.eot_err, 1);
        rd(15);
        rd(10);
        release_win();
        check("err_sticky", bus.eot_err, 1);

        do_reset();
        check("err_clr", bus.eot_err, 0);
        fill_const(9);
        send_pixels(7, 0, -1, 2'b00, -1);
        do_reset();
        fill_const(2);
        send_pixels(N, 0, -1, 2'b00, -1);
        rd(15);
        rd(0);
        check("rst_mid_15", ii_win[15], 32);

        bus.rd_valid    = 1'b1;
        bus.rd_addr     = 4'd15;
        bus.win_release = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_valid    = 1'b0;
        bus.win_release = 1'b0;
        check("relrd_rdv", bus.rd_data_valid, 1);
        check("relrd_data", bus.rd_data, 32);
        check("relrd_win", bus.win_valid, 0);
        check("relrd_fill", bus.din_ready, 1);
        fill_const(3);
        send_pixels(N, 10, -1, 2'b00, -1);
        rd(15);
        check("threes_15", ii_win[15], 48);
        release_win();

        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < N; k++) px[k] = $urandom_range(255);
            send_pixels(N, 30, $urandom_range(N + 3), 2'($urandom_range(3)), -1);
            for (int r = 0; r < 6; r++) rd($urandom_range(N - 1));
            release_win();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
